// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for mem_arbiter: FSM encodings, default limits,
// statistics counter width and small sizing/saturation helpers.
package mem_arbiter_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_e;

    localparam int DEF_STARVE_LIMIT = 8;
    localparam int DEF_BURST_MAX    = 4;
    localparam int STAT_W           = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            return v;
        end else begin
            return v + STAT_W'(1);
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_stats_counter.sv
// Saturating event counter used for arbitration statistics.
// Only present in builds with MEM_ARB_STATS_EN defined.
`ifdef MEM_ARB_STATS_EN
module arb_stats_counter
    import mem_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inc,
    output logic [STAT_W-1:0] o_count
);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= sat_inc(o_count);
        end else begin
            o_count <= o_count;
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Shares the processor memory port between the 6502 core and a DMA requester,
// stalling the core through cpu_rdy. Define MEM_ARB_STATS_EN for stall/grant counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int BURST_MAX    = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_wr_enable,
    input  logic              cpu_halt,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_wr_data,
    input  logic              dma_wr_enable,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_enable,
    input  logic [DATA_W-1:0] mem_rd_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] grant_count
`endif
);

    localparam int WAIT_W  = cnt_w(STARVE_LIMIT);
    localparam int BURST_W = cnt_w(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic               w_dma_own;

    // Ownership is gated by reset so a beat in flight is dropped immediately.
    assign w_dma_own = !reset && (r_state == S_DMA) && dma_req;

    // Route the owner onto the memory port; the non-owner's strobe never leaks.
    always_comb begin
        cpu_rd_data = mem_rd_data;
        dma_rd_data = mem_rd_data;
        dma_gnt     = w_dma_own;
        cpu_rdy     = !w_dma_own;
        if (w_dma_own) begin
            mem_address   = dma_address;
            mem_wr_data   = dma_wr_data;
            mem_wr_enable = dma_wr_enable;
        end else begin
            mem_address   = cpu_address;
            mem_wr_data   = cpu_wr_data;
            mem_wr_enable = cpu_wr_enable && !reset;
        end
    end

    // Next-state and counter update for the two-state arbiter.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            S_CPU: begin
                if (dma_req && ((r_wait_cnt == WAIT_LAST) || cpu_halt)) begin
                    w_state_nxt = S_DMA;
                    w_wait_nxt  = '0;
                    w_burst_nxt = '0;
                end else if (dma_req) begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end else begin
                    w_wait_nxt = '0;
                end
            end
            S_DMA: begin
                w_wait_nxt = '0;
                if (!dma_req) begin
                    w_state_nxt = S_CPU;
                end else if (!cpu_halt && (r_burst_cnt >= BURST_LAST)) begin
                    // Also catches a halt released after the count saturated.
                    w_state_nxt = S_CPU;
                end else if (r_burst_cnt != BURST_LAST) begin
                    w_burst_nxt = r_burst_cnt + BURST_W'(1);
                end else begin
                    w_burst_nxt = r_burst_cnt;
                end
            end
            default: begin
                w_state_nxt = S_CPU;
                w_wait_nxt  = '0;
                w_burst_nxt = '0;
            end
        endcase
    end

    // Arbiter state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_CPU;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

`ifdef MEM_ARB_STATS_EN
    arb_stats_counter u_stall_cnt (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_inc   (w_dma_own),
        .o_count (stall_count)
    );

    arb_stats_counter u_grant_cnt (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_inc   (w_dma_own),
        .o_count (grant_count)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, self-checking bench for mem_arbiter (STARVE_LIMIT=8, BURST_MAX=4)
// with a small memory model and a scoreboard of expected DMA beats.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_enable;
    logic        cpu_halt;
    logic [7:0]  cpu_rd_data;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_address;
    logic [7:0]  dma_wr_data;
    logic        dma_wr_enable;
    logic        dma_gnt;
    logic [7:0]  dma_rd_data;
    logic [15:0] mem_address;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_enable;
    logic [7:0]  mem_rd_data;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] grant_count;
`endif

    logic        tb_ld;
    logic [15:0] tb_ld_addr;
    logic [7:0]  tb_ld_data;
    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
    } beat_t;
    beat_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int lat;

    mem_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .STARVE_LIMIT (8),
        .BURST_MAX    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_address   (cpu_address),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_wr_enable (cpu_wr_enable),
        .cpu_halt      (cpu_halt),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_rdy       (cpu_rdy),
        .dma_req       (dma_req),
        .dma_address   (dma_address),
        .dma_wr_data   (dma_wr_data),
        .dma_wr_enable (dma_wr_enable),
        .dma_gnt       (dma_gnt),
        .dma_rd_data   (dma_rd_data),
        .mem_address   (mem_address),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .mem_rd_data   (mem_rd_data)
`ifdef MEM_ARB_STATS_EN
        ,
        .stall_count   (stall_count),
        .grant_count   (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read memory; the bench preloads through its own port.
    assign mem_rd_data = mem[mem_address];
    always @(posedge clk) begin
        if (tb_ld) begin
            mem[tb_ld_addr] <= tb_ld_data;
        end else if (mem_wr_enable) begin
            mem[mem_address] <= mem_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Compare the current (granted) cycle against the oldest expected beat.
    task automatic sb_check(input string tag);
        beat_t e;
        check({tag, "_gnt"}, 32'(dma_gnt), 32'd1);
        check({tag, "_sb_level"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_addr"}, 32'(mem_address), 32'(e.addr));
            check({tag, "_we"}, 32'(mem_wr_enable), 32'(e.we));
            if (e.we) begin
                check({tag, "_wdata"}, 32'(mem_wr_data), 32'(e.data));
            end else begin
                check({tag, "_dma_rdata"}, 32'(dma_rd_data), 32'(e.data));
                check({tag, "_cpu_rdata"}, 32'(cpu_rd_data), 32'(e.data));
            end
        end
    endtask

    // Bounded wait for a grant; lat = cycles since the call, -1 on timeout.
    task automatic wait_grant(input int cpu_wr_at, output int lat_o);
        lat_o = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == cpu_wr_at) begin
                cpu_address   = 16'h0300;
                cpu_wr_data   = 8'h11;
                cpu_wr_enable = 1'b1;
            end
            @(negedge clk);
            if (dma_gnt === 1'b1) begin
                lat_o = i;
                break;
            end
            next();
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_address = 16'h0000; cpu_wr_data = 8'h00; cpu_wr_enable = 1'b0; cpu_halt = 1'b0;
        dma_req = 1'b0; dma_address = 16'h0000; dma_wr_data = 8'h00; dma_wr_enable = 1'b0;
        tb_ld = 1'b1; tb_ld_addr = 16'h1234; tb_ld_data = 8'hA5;
        next();
        tb_ld_addr = 16'h0600; tb_ld_data = 8'h3C;
        next();
        tb_ld = 1'b0;

        // Reset holds the port quiet even with both sides requesting writes.
        cpu_wr_enable = 1'b1; dma_req = 1'b1; dma_wr_enable = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_gnt", 32'(dma_gnt), 32'd0);
        check("rst_we", 32'(mem_wr_enable), 32'd0);
        next();
        reset = 1'b0; cpu_wr_enable = 1'b0; dma_req = 1'b0; dma_wr_enable = 1'b0;
        next();

        // Test 2: constant request -> 8 core cycles, 4 DMA beats, repeating.
        dma_address = 16'h0100; dma_req = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            check("t2_rdy", 32'(cpu_rdy), ((c % 12) < 8) ? 32'd1 : 32'd0);
            check("t2_gnt", 32'(dma_gnt), ((c % 12) >= 8) ? 32'd1 : 32'd0);
            next();
        end
        dma_req = 1'b0;
        @(negedge clk);
        check("t2_release", 32'(cpu_rdy), 32'd1);
        next();

        // Test 3: DMA write wins the grant cycle; the core write lands afterwards.
        dma_address = 16'h0200; dma_wr_data = 8'h5A; dma_wr_enable = 1'b1; dma_req = 1'b1;
        sb_q.push_back('{addr: 16'h0200, data: 8'h5A, we: 1'b1});
        wait_grant(8, lat);
        check("t3_lat", 32'(lat), 32'd8);
        check("t3_stall", 32'(cpu_rdy), 32'd0);
        sb_check("t3");
        next();
        dma_req = 1'b0; dma_wr_enable = 1'b0;
        @(negedge clk);
        check("t3_cpu_rdy", 32'(cpu_rdy), 32'd1);
        check("t3_cpu_addr", 32'(mem_address), 32'h0300);
        check("t3_cpu_wdata", 32'(mem_wr_data), 32'h11);
        check("t3_cpu_we", 32'(mem_wr_enable), 32'd1);
        next();
        cpu_wr_enable = 1'b0;
        check("t3_mem_dma", 32'(mem[16'h0200]), 32'h5A);
        check("t3_mem_cpu", 32'(mem[16'h0300]), 32'h11);

        // Test 4: DMA read returns memory data in the grant cycle.
        dma_address = 16'h1234; dma_req = 1'b1;
        sb_q.push_back('{addr: 16'h1234, data: 8'hA5, we: 1'b0});
        wait_grant(-1, lat);
        check("t4_lat", 32'(lat), 32'd8);
        sb_check("t4");
        next();
        dma_req = 1'b0;
        @(negedge clk);
        check("t4_release", 32'(cpu_rdy), 32'd1);
        next();

        // Test 5a: halted core, 20 consecutive grants.
        cpu_halt = 1'b1; dma_address = 16'h0400; dma_req = 1'b1;
        @(negedge clk);
        check("t5a_pre", 32'(dma_gnt), 32'd0);
        next();
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            check("t5a_gnt", 32'(dma_gnt), 32'd1);
            check("t5a_rdy", 32'(cpu_rdy), 32'd0);
            next();
        end
        dma_req = 1'b0;
        @(negedge clk);
        check("t5a_drop", 32'(cpu_rdy), 32'd1);
        next();

        // Test 5b: halt released on beat 10 with the burst count saturated.
        dma_req = 1'b1;
        @(negedge clk);
        check("t5b_pre", 32'(dma_gnt), 32'd0);
        next();
        for (int b = 1; b <= 10; b++) begin
            if (b == 10) cpu_halt = 1'b0;
            @(negedge clk);
            check("t5b_gnt", 32'(dma_gnt), 32'd1);
            next();
        end
        @(negedge clk);
        check("t5b_exit_gnt", 32'(dma_gnt), 32'd0);
        check("t5b_exit_rdy", 32'(cpu_rdy), 32'd1);
        dma_req = 1'b0;
        next();

        // Test 1: reset on the second beat of a halted write burst.
        cpu_halt = 1'b1; dma_address = 16'h0500; dma_wr_data = 8'h77;
        dma_wr_enable = 1'b1; dma_req = 1'b1;
        @(negedge clk);
        check("t1_pre", 32'(dma_gnt), 32'd0);
        next();
        @(negedge clk);
        check("t1_beat1", 32'(dma_gnt), 32'd1);
        next();
        dma_wr_data = 8'h88;
        reset = 1'b1;
        @(negedge clk);
        check("t1_rst_we", 32'(mem_wr_enable), 32'd0);
        check("t1_rst_gnt", 32'(dma_gnt), 32'd0);
        check("t1_rst_rdy", 32'(cpu_rdy), 32'd1);
        next();
        cpu_halt = 1'b0; dma_wr_enable = 1'b0; reset = 1'b0;
        sb_q.push_back('{addr: 16'h0500, data: 8'h77, we: 1'b0});
        wait_grant(-1, lat);
        check("t1_lat", 32'(lat), 32'd8);
        sb_check("t1");
        next();
        dma_req = 1'b0;
        @(negedge clk);
        check("t1_release", 32'(cpu_rdy), 32'd1);
        next();

        // Test 6: request dropped after two beats, then re-requested.
        reset = 1'b1;
        next();
        reset = 1'b0;
        dma_address = 16'h0600; dma_req = 1'b1;
        sb_q.push_back('{addr: 16'h0600, data: 8'h3C, we: 1'b0});
        sb_q.push_back('{addr: 16'h0600, data: 8'h3C, we: 1'b0});
        wait_grant(-1, lat);
        check("t6_lat1", 32'(lat), 32'd8);
        sb_check("t6_b1");
        next();
        @(negedge clk);
        sb_check("t6_b2");
        next();
        dma_req = 1'b0;
        @(negedge clk);
        check("t6_drop_rdy", 32'(cpu_rdy), 32'd1);
        check("t6_drop_gnt", 32'(dma_gnt), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check("t6_grant_count", 32'(grant_count), 32'd2);
        check("t6_stall_count", 32'(stall_count), 32'd2);
`endif
        next();
        dma_req = 1'b1;
        sb_q.push_back('{addr: 16'h0600, data: 8'h3C, we: 1'b0});
        wait_grant(-1, lat);
        check("t6_lat2", 32'(lat), 32'd8);
        sb_check("t6_b3");
        next();
        dma_req = 1'b0;
        @(negedge clk);
        check("t6_release", 32'(cpu_rdy), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        next();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
